dirty_tracker: RTL
==================

DIRTY_TRACKER -- requirements
Module: dirty_tracker

Interface
REQ-001 Parameter NUM_LINES, default 4, number of tracked cache lines; the block SHALL support 2 to 64.
REQ-002 Parameter IDX_W, default 2, line-index width; it SHALL equal clog2(NUM_LINES).
REQ-003 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 resetn  in  1  reset, asynchronous and active-low.
REQ-005 cpuWren  in  1  CPU write hit to line cpuIdx.
REQ-006 cpuIdx  in  IDX_W  line index for cpuWren.
REQ-007 fillWren  in  1  line fillIdx refilled from RAM.
REQ-008 fillIdx  in  IDX_W  line index for fillWren.
REQ-009 evictReq  in  1  request to evict line evictIdx; one-cycle pulse, sampled only in IDLE.
REQ-010 evictIdx  in  IDX_W  line to evict.
REQ-011 wbAck  in  1  RAM has accepted the write-back; one-cycle pulse.
REQ-012 wbReq  out  1  write-back request; held high until wbAck.
REQ-013 wbIdx  out  IDX_W  line being written back; stable while wbReq is high.
REQ-014 evictDone  out  1  one-cycle pulse; the evicted line is clean and invalid.
REQ-015 busy  out  1  high whenever the FSM is not in IDLE.
REQ-016 dirty  out  NUM_LINES  per-line dirty bits.
REQ-017 valid  out  NUM_LINES  per-line valid bits.
REQ-018 dirtyCount  out  IDX_W+1  population count of dirty, registered to match dirty.

Function
REQ-019 FSM states: IDLE, WB, DONE, plus FLUSH_SCAN when compiled in.
- IDLE->WB on evictReq when dirty[evictIdx]=1.
- IDLE->DONE on evictReq when dirty[evictIdx]=0.
REQ-020 On the IDLE->WB transition, wbIdx SHALL latch evictIdx and wbReq SHALL rise on the next edge.
REQ-021 WB->DONE on wbAck: clear dirty[wbIdx] and wbReq on the same edge.
REQ-022 DONE SHALL last exactly one cycle: evictDone=1, valid[latched idx] cleared, then return to IDLE.
REQ-023 A clean eviction SHALL give evictDone exactly 2 cycles after evictReq.
REQ-024 A dirty eviction SHALL give evictDone exactly 1 cycle after the wbAck edge.
REQ-025 cpuWren SHALL set dirty[cpuIdx] and valid[cpuIdx] on the next edge, in any FSM state.
REQ-026 fillWren SHALL set valid[fillIdx] and clear dirty[fillIdx].
REQ-027 cpuWren and fillWren to the same index in the same cycle: the line SHALL end valid and dirty (CPU write wins).
REQ-028 cpuWren to wbIdx in the same cycle as wbAck: dirty SHALL stay 1 and valid SHALL stay 1 (the DONE invalidate is suppressed for that line).
REQ-029 cpuWren to the latched line while in WB: dirty SHALL stay set after wbAck and valid SHALL stay 1.
REQ-030 evictReq while busy=1 SHALL be ignored, with no queuing.
REQ-031 wbAck outside WB SHALL be ignored.
REQ-032 Different-index updates in the same cycle SHALL all take effect independently.
REQ-033 dirtyCount SHALL reflect dirty exactly, including NUM_LINES lines all dirty (the full count).

Reset
REQ-034 While resetn=0, at any time including mid-write-back, the block SHALL force:
- FSM to IDLE
- dirty=0, valid=0, dirtyCount=0
- wbReq=0, wbIdx=0, evictDone=0, busy=0
REQ-035 A wbAck arriving in the first cycle after reset release SHALL be ignored.

Configuration
REQ-036 Macro DIRTY_TRACKER_FLUSH_EN, when defined, SHALL add ports flushReq (in, 1) and flushDone (out, 1) and the state FLUSH_SCAN.
REQ-037 With the macro defined, flushReq in IDLE SHALL scan index 0..NUM_LINES-1, one index per cycle:
- each dirty line goes through WB/wbAck, then scanning resumes at the next index;
- clean lines are skipped;
- valid bits are left unchanged.
REQ-038 After the last index the scan SHALL wrap to IDLE, pulse flushDone for 1 cycle, and dirtyCount SHALL then read 0 unless cpuWren intervened.
REQ-039 Without the macro, neither port nor state SHALL exist and behaviour SHALL be as in REQ-019..033.

Verification
REQ-040 Reset, then cpuWren idx 2 -> dirty=4'b0100, valid=4'b0100, dirtyCount=1 one cycle later.
REQ-041 Line 2 dirty, evictReq idx 2, wbAck 3 cycles after wbReq -> wbIdx=2, then evictDone one cycle after wbAck, dirty=0, valid[2]=0.
REQ-042 Line 1 clean and valid, evictReq idx 1 -> wbReq never rises, evictDone 2 cycles after the request, valid[1]=0.
REQ-043 During WB on idx 3, cpuWren idx 3 coincident with wbAck -> dirty[3]=1, valid[3]=1, evictDone pulses once.
REQ-044 During WB, assert resetn=0 -> wbReq=0 and dirty=0 immediately; a stray wbAck after release causes no change.
REQ-045 With DIRTY_TRACKER_FLUSH_EN, dirty=4'b1010, flushReq -> write-backs to idx 1 then idx 3, flushDone pulse, dirty=0, valid unchanged.

Source files
------------

// File: rtl/dirty_tracker.sv
// dirty_tracker: per-line dirty/valid tracking with an evict/write-back FSM; line updates land one edge after the request.
// wbReq is held until wbAck (no timeout); evictReq while busy is dropped; DIRTY_TRACKER_FLUSH_EN adds a flush scan.
module dirty_tracker #(
  parameter int NUM_LINES = 4,
  parameter int IDX_W     = 2
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 cpuWren,
  input  logic [IDX_W-1:0]     cpuIdx,
  input  logic                 fillWren,
  input  logic [IDX_W-1:0]     fillIdx,
  input  logic                 evictReq,
  input  logic [IDX_W-1:0]     evictIdx,
  input  logic                 wbAck,
  output logic                 wbReq,
  output logic [IDX_W-1:0]     wbIdx,
  output logic                 evictDone,
  output logic                 busy,
  output logic [NUM_LINES-1:0] dirty,
  output logic [NUM_LINES-1:0] valid,
`ifdef DIRTY_TRACKER_FLUSH_EN
  input  logic                 flushReq,
  output logic                 flushDone,
`endif
  output logic [IDX_W:0]       dirtyCount
);

`ifdef DIRTY_TRACKER_FLUSH_EN
  typedef enum logic [1:0] {IDLE, WB, DONE, FLUSH_SCAN} state_t;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINES - 1);
  logic             flushing;
  logic [IDX_W-1:0] scan_idx;
`else
  typedef enum logic [1:0] {IDLE, WB, DONE} state_t;
`endif

  state_t           state;
  logic [IDX_W-1:0] line_idx;
  logic             rewritten;

  logic                 cpu_hit_wb;
  logic                 ack_clr;
  logic                 inval;
  logic [NUM_LINES-1:0] dirty_nxt;
  logic [NUM_LINES-1:0] valid_nxt;
  logic [IDX_W:0]       cnt_nxt;

  // A CPU write to the line under eviction keeps it dirty and valid: its new data postdates the write-back.
  assign cpu_hit_wb = cpuWren && (cpuIdx == wbIdx);
  assign ack_clr    = (state == WB) && wbAck && !rewritten && !cpu_hit_wb;
  assign inval      = (state == DONE) && !rewritten;

  always_comb begin
    dirty_nxt = dirty;
    valid_nxt = valid;
    cnt_nxt   = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (ack_clr && (wbIdx == IDX_W'(i)))
        dirty_nxt[i] = 1'b0;
      if (inval && (line_idx == IDX_W'(i)))
        valid_nxt[i] = 1'b0;
      if (fillWren && (fillIdx == IDX_W'(i))) begin
        valid_nxt[i] = 1'b1;
        dirty_nxt[i] = 1'b0;
      end
      if (cpuWren && (cpuIdx == IDX_W'(i))) begin
        valid_nxt[i] = 1'b1;
        dirty_nxt[i] = 1'b1;
      end
      cnt_nxt = cnt_nxt + {{IDX_W{1'b0}}, dirty_nxt[i]};
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dirty      <= '0;
      valid      <= '0;
      dirtyCount <= '0;
    end else begin
      dirty      <= dirty_nxt;
      valid      <= valid_nxt;
      dirtyCount <= cnt_nxt;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      wbReq     <= 1'b0;
      wbIdx     <= '0;
      line_idx  <= '0;
      rewritten <= 1'b0;
      evictDone <= 1'b0;
      busy      <= 1'b0;
`ifdef DIRTY_TRACKER_FLUSH_EN
      flushing  <= 1'b0;
      scan_idx  <= '0;
      flushDone <= 1'b0;
`endif
    end else begin
      evictDone <= 1'b0;
`ifdef DIRTY_TRACKER_FLUSH_EN
      flushDone <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (evictReq) begin
            busy      <= 1'b1;
            line_idx  <= evictIdx;
            rewritten <= cpuWren && (cpuIdx == evictIdx);
            if (dirty[evictIdx]) begin
              state <= WB;
              wbReq <= 1'b1;
              wbIdx <= evictIdx;
            end else begin
              state <= DONE;
            end
          end
`ifdef DIRTY_TRACKER_FLUSH_EN
          else if (flushReq) begin
            state    <= FLUSH_SCAN;
            busy     <= 1'b1;
            flushing <= 1'b1;
            scan_idx <= '0;
          end
`endif
        end
        WB: begin
          if (cpu_hit_wb)
            rewritten <= 1'b1;
          if (wbAck) begin
            wbReq <= 1'b0;
`ifdef DIRTY_TRACKER_FLUSH_EN
            if (flushing) begin
              if (scan_idx == LAST_IDX) begin
                state     <= IDLE;
                busy      <= 1'b0;
                flushing  <= 1'b0;
                flushDone <= 1'b1;
              end else begin
                state    <= FLUSH_SCAN;
                scan_idx <= scan_idx + IDX_W'(1);
              end
            end else begin
              state <= DONE;
            end
`else
            state <= DONE;
`endif
          end
        end
        DONE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          evictDone <= 1'b1;
          rewritten <= 1'b0;
        end
`ifdef DIRTY_TRACKER_FLUSH_EN
        FLUSH_SCAN: begin
          // Flush writes back but never invalidates, so it bypasses DONE.
          if (dirty[scan_idx]) begin
            state     <= WB;
            wbReq     <= 1'b1;
            wbIdx     <= scan_idx;
            line_idx  <= scan_idx;
            rewritten <= cpuWren && (cpuIdx == scan_idx);
          end else if (scan_idx == LAST_IDX) begin
            state     <= IDLE;
            busy      <= 1'b0;
            flushing  <= 1'b0;
            flushDone <= 1'b1;
          end else begin
            scan_idx <= scan_idx + IDX_W'(1);
          end
        end
`endif
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          wbReq <= 1'b0;
        end
      endcase
    end
  end

endmodule
